zet_memif: RTL and testbench
============================

// Module: zet_memif
// PURPOSE
//  Memory/IO bus interface stage directly downstream of the exec unit. Takes the
//  exec access request (addr, wr_data, we, m_io, byteop) and runs it as one or
//  two 16-bit Wishbone-style classic bus cycles. Returns read data on memout and
//  holds block high until the access completes. Odd-address word accesses are
//  split into two byte cycles.
// PARAMETERS
//  ADDR_W  20  memory address width in bytes; IO space is fixed at 16 bits
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   1   sequencer: current micro-op accesses memory/IO; level-held
//  addr       in   20  byte address from exec (IO: addr[15:0] only)
//  wr_data    in   16  store data from exec
//  we         in   1   1=write, 0=read
//  m_io       in   1   1=IO space, 0=memory space
//  byteop     in   1   1=byte access, 0=word access
//  memout     out  16  read data to exec; byte reads zero-extended
//  block      out  1   stall exec/sequencer; = req & (state!=DONE)
//  wb_adr_o   out  19  word address, byte addr [ADDR_W-1:1]
//  wb_dat_o   out  16  write data, lane-steered
//  wb_dat_i   in   16  read data
//  wb_sel_o   out  2   byte lane enables; [0]=even byte, [1]=odd byte
//  wb_we_o    out  1   write strobe qualifier
//  wb_tga_o   out  1   1=IO cycle
//  wb_cyc_o   out  1   bus cycle active; wb_stb_o is the same signal
//  wb_stb_o   out  1   strobe
//  wb_ack_i   in   1   slave ack; 1 cycle per transfer
// BEHAVIOUR
//  Reset: state=IDLE, all wb_* outputs 0, memout=16'h0000.
//  block is combinational: req & (state!=DONE). It rises in the same cycle req rises.
//  FSM states:
//   IDLE:  req=1 -> CYC1 and latch addr/we/m_io/byteop/wr_data.
//          split = ~byteop & addr[0]. Otherwise stay in IDLE.
//   CYC1:  stb/cyc=1 (registered, first asserted the cycle after req is sampled).
//          On ack: split -> CYC2, else -> DONE.
//   CYC2:  second byte cycle at addr+1. On ack -> DONE.
//   DONE:  1 cycle, block=0, memout valid. Exec writes back this cycle. -> IDLE.
//  stb is deasserted for at least one cycle between CYC1 and CYC2.
//  Lane rules for CYC1:
//   - Even word: sel=11, dat_o=wr_data, memout=dat_i.
//   - Byte at even addr: sel=01, dat_o={wr[7:0],wr[7:0]}, memout={8'h00,dat_i[7:0]}.
//   - Byte at odd addr: sel=10, same dat_o, memout={8'h00,dat_i[15:8]}.
//   - Odd word: CYC1 sel=10 with low byte wr[7:0] and memout[7:0]<=dat_i[15:8].
//     CYC2 sel=01 at addr+1 with high byte wr[15:8] and memout[15:8]<=dat_i[7:0].
//  addr+1 wraps modulo 2^ADDR_W for memory and modulo 2^16 for IO.
//  Example: F_FFFF -> 0_0000.
//  Read latency with ack on first stb cycle:
//   - Aligned access: block high 3 cycles, DONE on the 4th.
//   - Split access: 5 cycles.
//  Writes: memout is not updated.
//  Boundary conditions:
//   - ack while stb=0: ignored.
//   - req drops mid-cycle: the bus cycle completes (stb held to ack), then -> IDLE.
//     DONE is skipped and memout is not updated.
//   - No ack: wait indefinitely. There is no timeout.
//   - rst_n low in any state: immediate IDLE, stb/cyc drop asynchronously.
//   - req held high in DONE: treated as a new access on the following IDLE cycle.
//     The sequencer must drop req or change the micro-op in DONE.
// STRUCTURE
//  - defines.v (shared): MEMIF_IDLE/CYC1/CYC2/DONE 2-bit encodings, SEL_LO=2'b01,
//    SEL_HI=2'b10, SEL_W=2'b11.
//  - Sub-module zet_memif_lane (combinational): from addr[0], byteop and phase,
//    produces sel, dat_o steering and read-byte merge enables.
//  - FSM, address incrementer and memout registers live in zet_memif.
// TESTING
//  1. Word read at 0x01234 (even), slave returns 16'hBEEF with 0-wait ack
//     -> one cycle, sel=11, adr=0x091A, memout=BEEF in DONE, block high 3 cycles.
//  2. Word write 16'hA55A at 0x00101 (odd) -> two cycles:
//     adr=0x080 sel=10 dat[15:8]=5A, then adr=0x081 sel=01 dat[7:0]=A5.
//  3. Byte read at 0x00003, dat_i=16'h7F80 -> sel=10, memout=16'h007F.
//     Byte read at 0x00002 -> sel=01, memout=16'h0080.
//  4. Odd word read at 0xFFFFF -> second cycle adr=0x00000 (wrap).
//     IO odd word at 0xFFFF -> second cycle IO adr=0x0000, tga=1 on both cycles.
//  5. 3 wait states on each ack for a split read -> block stays high throughout,
//     stb stays low for at least 1 cycle between cycles, memout merged correctly.
//  6. rst_n pulsed low during CYC2 -> stb/cyc/block drop immediately, memout=0.
//     req dropped in CYC1 -> cycle finishes on ack, no DONE, no memout update.

Source files
------------

// File: rtl/zet_memif_pkg.sv
// Shared types for the zet memory/IO bus interface stage.
// FSM encodings, lane-select codes and the latched access command.
package zet_memif_pkg;

  typedef enum logic [1:0] {
    MEMIF_IDLE = 2'b00,
    MEMIF_CYC1 = 2'b01,
    MEMIF_CYC2 = 2'b10,
    MEMIF_DONE = 2'b11
  } memif_state_t;

  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;
  localparam logic [1:0] SEL_W  = 2'b11;

  localparam int IO_AW = 16;

  typedef struct packed {
    logic [15:0] wr_data;
    logic        we;
    logic        m_io;
    logic        byteop;
    logic        split;
  } memif_cmd_t;

  function automatic logic [15:0] merge_bytes(
    input logic [15:0] old_v,
    input logic [15:0] new_v,
    input logic [1:0]  en
  );
    logic [15:0] m;
    m = {{8{en[1]}}, {8{en[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/zet_memif_if.sv
// Wishbone-style classic bus between zet_memif and memory/IO slaves.
// wb_tga_o marks an IO-space cycle.
interface zet_memif_if #(
  parameter int ADDR_W = 20
);

  logic [ADDR_W-2:0] wb_adr_o;
  logic [15:0]       wb_dat_o;
  logic [15:0]       wb_dat_i;
  logic [1:0]        wb_sel_o;
  logic              wb_we_o;
  logic              wb_tga_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_we_o, wb_tga_o,
    output wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_we_o, wb_tga_o,
    input  wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/zet_memif_lane.sv
// Byte-lane steering: select lanes, write data placement and
// which bytes of the returned data land where in memout.
module zet_memif_lane
  import zet_memif_pkg::*;
(
  input  logic        a0_i,
  input  logic        byteop_i,
  input  logic        phase_i,
  input  logic [15:0] wr_data_i,
  input  logic [15:0] dat_i,
  output logic [1:0]  sel_o,
  output logic [15:0] dat_o,
  output logic [15:0] rdata_o,
  output logic [1:0]  wen_o
);

  always_comb begin
    sel_o   = SEL_W;
    dat_o   = wr_data_i;
    rdata_o = dat_i;
    wen_o   = 2'b11;
    unique case (1'b1)
      phase_i: begin
        sel_o   = SEL_LO;
        dat_o   = {2{wr_data_i[15:8]}};
        rdata_o = {dat_i[7:0], 8'h00};
        wen_o   = 2'b10;
      end
      (!phase_i && !byteop_i && !a0_i): begin
        sel_o   = SEL_W;
        dat_o   = wr_data_i;
        rdata_o = dat_i;
        wen_o   = 2'b11;
      end
      (!phase_i && byteop_i && !a0_i): begin
        sel_o   = SEL_LO;
        dat_o   = {2{wr_data_i[7:0]}};
        rdata_o = {8'h00, dat_i[7:0]};
        wen_o   = 2'b11;
      end
      // odd byte, or first half of a split word
      (!phase_i && a0_i): begin
        sel_o   = SEL_HI;
        dat_o   = {2{wr_data_i[7:0]}};
        rdata_o = {8'h00, dat_i[15:8]};
        wen_o   = byteop_i ? 2'b11 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/zet_memif.sv
// Memory/IO bus stage: runs exec accesses as one or two
// 16-bit classic bus cycles and stalls exec until done.
module zet_memif
  import zet_memif_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wr_data,
  input  logic              we,
  input  logic              m_io,
  input  logic              byteop,
  output logic [15:0]       memout,
  output logic              block,
  zet_memif_if.master       wb
);

  memif_state_t      state_q;
  memif_cmd_t        cmd_q, cmd_d;
  logic [ADDR_W-2:0] wadr_q, wadr_d, wadr_inc;
  logic [ADDR_W-2:0] adr_q;
  logic              a0_q;
  logic              stb_q;
  logic [1:0]        sel_q;
  logic [15:0]       dat_q;
  logic              we_q;
  logic              tga_q;
  logic [15:0]       rbuf_q, rbuf_d;
  logic [15:0]       memout_q;

  logic              phase;
  logic [1:0]        lane_sel;
  logic [15:0]       lane_dat;
  logic [15:0]       lane_rdata;
  logic [1:0]        lane_wen;

  assign phase = (state_q == MEMIF_CYC2);

  always_comb begin
    cmd_d.wr_data = wr_data;
    cmd_d.we      = we;
    cmd_d.m_io    = m_io;
    cmd_d.byteop  = byteop;
    cmd_d.split   = ~byteop & addr[0];
    wadr_d = m_io ? {{(ADDR_W-IO_AW){1'b0}}, addr[IO_AW-1:1]}
                  : addr[ADDR_W-1:1];
  end

  // IO space wraps at 64K bytes, memory at 2^ADDR_W
  always_comb begin
    wadr_inc = wadr_q + 1'b1;
    if (cmd_q.m_io)
      wadr_inc[ADDR_W-2:IO_AW-1] = '0;
  end

  zet_memif_lane u_lane (
    .a0_i      (a0_q),
    .byteop_i  (cmd_q.byteop),
    .phase_i   (phase),
    .wr_data_i (cmd_q.wr_data),
    .dat_i     (wb.wb_dat_i),
    .sel_o     (lane_sel),
    .dat_o     (lane_dat),
    .rdata_o   (lane_rdata),
    .wen_o     (lane_wen)
  );

  assign rbuf_d = merge_bytes(rbuf_q, lane_rdata, lane_wen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MEMIF_IDLE;
      cmd_q    <= '0;
      wadr_q   <= '0;
      a0_q     <= 1'b0;
      stb_q    <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      tga_q    <= 1'b0;
      rbuf_q   <= '0;
      memout_q <= '0;
    end else begin
      unique case (state_q)
        MEMIF_IDLE: begin
          if (req) begin
            state_q <= MEMIF_CYC1;
            cmd_q   <= cmd_d;
            wadr_q  <= wadr_d;
            a0_q    <= addr[0];
            rbuf_q  <= '0;
          end
        end
        MEMIF_CYC1, MEMIF_CYC2: begin
          if (!stb_q) begin
            stb_q <= 1'b1;
            adr_q <= phase ? wadr_inc : wadr_q;
            sel_q <= lane_sel;
            dat_q <= lane_dat;
            we_q  <= cmd_q.we;
            tga_q <= cmd_q.m_io;
          end else if (wb.wb_ack_i) begin
            stb_q  <= 1'b0;
            sel_q  <= '0;
            we_q   <= 1'b0;
            rbuf_q <= rbuf_d;
            // an abandoned access finishes its bus cycle silently
            if (!req) begin
              state_q <= MEMIF_IDLE;
            end else if (!phase && cmd_q.split) begin
              state_q <= MEMIF_CYC2;
            end else begin
              state_q <= MEMIF_DONE;
              if (!cmd_q.we)
                memout_q <= rbuf_d;
            end
          end
        end
        MEMIF_DONE: state_q <= MEMIF_IDLE;
        default:    state_q <= MEMIF_IDLE;
      endcase
    end
  end

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_tga_o = tga_q;
  assign wb.wb_cyc_o = stb_q;
  assign wb.wb_stb_o = stb_q;

  assign memout = memout_q;
  assign block  = rst_n & req & (state_q != MEMIF_DONE);

endmodule

// File: tb/tb_zet_memif.sv
// Directed bench for zet_memif: expected bus cycles and memout
// values are queued up front and checked as the DUT produces them.
module tb_zet_memif;

  typedef struct {
    logic [18:0] adr;
    logic [1:0]  sel;
    logic        we;
    logic        tga;
    logic [15:0] dat;
    logic [15:0] dmask;
    logic [15:0] rdat;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [19:0] addr;
  logic [15:0] wr_data;
  logic        we;
  logic        m_io;
  logic        byteop;
  logic [15:0] memout;
  logic        block;

  int vecs = 0;
  int errs = 0;

  cyc_t        cq[$];
  logic [15:0] mq[$];
  logic [15:0] model_mem;

  zet_memif_if #(.ADDR_W(20)) bus ();

  zet_memif #(.ADDR_W(20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr    (addr),
    .wr_data (wr_data),
    .we      (we),
    .m_io    (m_io),
    .byteop  (byteop),
    .memout  (memout),
    .block   (block),
    .wb      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cyc(input logic [18:0] adr, input logic [1:0] sel,
                          input logic w, input logic tga,
                          input logic [15:0] dat, input logic [15:0] dmask,
                          input logic [15:0] rdat);
    cyc_t c;
    c.adr = adr; c.sel = sel; c.we = w; c.tga = tga;
    c.dat = dat; c.dmask = dmask; c.rdat = rdat;
    cq.push_back(c);
  endtask

  task automatic push_mem(input logic is_rd, input logic [15:0] v);
    if (is_rd) model_mem = v;
    mq.push_back(model_mem);
  endtask

  task automatic run(input logic [19:0] a, input logic [15:0] wd,
                     input logic w, input logic io, input logic bo,
                     input int ws, input bit spur, input int exp_blk);
    int   blk;
    int   wc;
    bit   done;
    bit   ackp;
    cyc_t c;
    @(negedge clk);
    addr = a; wr_data = wd; we = w; m_io = io; byteop = bo;
    req = 1'b1;
    #1 chk("block_rise", block, 1);
    blk = 1; wc = 0; done = 0; ackp = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (ackp) chk("stb_gap", bus.wb_stb_o, 0);
      ackp = 0;
      if (!block) begin
        done = 1;
        bus.wb_ack_i = 1'b0;
        chk("block_cycles", blk, exp_blk);
        chk("cycles_left", cq.size(), 0);
        if (mq.size() != 0) chk("memout", memout, mq.pop_front());
      end else begin
        blk++;
        if (bus.wb_stb_o) begin
          chk("cyc_eq_stb", bus.wb_cyc_o, 1);
          if (wc < ws) begin
            wc++;
            bus.wb_ack_i = 1'b0;
          end else if (cq.size() == 0) begin
            chk("extra_cycle", cq.size(), 1);
            bus.wb_ack_i = 1'b1;
            ackp = 1;
          end else begin
            c = cq.pop_front();
            chk("adr", bus.wb_adr_o, c.adr);
            chk("sel", bus.wb_sel_o, c.sel);
            chk("we", bus.wb_we_o, c.we);
            chk("tga", bus.wb_tga_o, c.tga);
            chk("dat_o", bus.wb_dat_o & c.dmask, c.dat & c.dmask);
            bus.wb_dat_i = c.rdat;
            bus.wb_ack_i = 1'b1;
            wc = 0;
            ackp = 1;
          end
        end else begin
          bus.wb_ack_i = spur;
        end
      end
    end
    if (!done) chk("timeout", done, 1);
    req = 1'b0;
    bus.wb_ack_i = 1'b0;
    cq.delete();
    mq.delete();
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; wr_data = '0;
    we = 1'b0; m_io = 1'b0; byteop = 1'b0;
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = '0;
    model_mem = 16'h0000;

    #2;
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    chk("rst_sel", bus.wb_sel_o, 0);
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_tga", bus.wb_tga_o, 0);
    chk("rst_dat", bus.wb_dat_o, 0);
    chk("rst_memout", memout, 0);
    chk("rst_block", block, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // aligned word read
    push_cyc(19'h0091A, 2'b11, 0, 0, 16'h0, 16'h0, 16'hBEEF);
    push_mem(1, 16'hBEEF);
    run(20'h01234, 16'h0, 0, 0, 0, 0, 0, 3);

    // odd word write, split in two
    push_cyc(19'h00080, 2'b10, 1, 0, 16'h5A00, 16'hFF00, 16'h0);
    push_cyc(19'h00081, 2'b01, 1, 0, 16'h00A5, 16'h00FF, 16'h0);
    push_mem(0, 16'h0);
    run(20'h00101, 16'hA55A, 1, 0, 0, 0, 0, 5);

    // byte reads and an odd byte write
    push_cyc(19'h00001, 2'b10, 0, 0, 16'h0, 16'h0, 16'h7F80);
    push_mem(1, 16'h007F);
    run(20'h00003, 16'h0, 0, 0, 1, 0, 0, 3);
    push_cyc(19'h00001, 2'b01, 0, 0, 16'h0, 16'h0, 16'h7F80);
    push_mem(1, 16'h0080);
    run(20'h00002, 16'h0, 0, 0, 1, 0, 0, 3);
    push_cyc(19'h00002, 2'b10, 1, 0, 16'h1212, 16'hFFFF, 16'h0);
    push_mem(0, 16'h0);
    run(20'h00005, 16'h3412, 1, 0, 1, 0, 0, 3);

    // address wrap, memory then IO
    push_cyc(19'h7FFFF, 2'b10, 0, 0, 16'h0, 16'h0, 16'hC3A5);
    push_cyc(19'h00000, 2'b01, 0, 0, 16'h0, 16'h0, 16'h5A96);
    push_mem(1, 16'h96C3);
    run(20'hFFFFF, 16'h0, 0, 0, 0, 0, 0, 5);
    push_cyc(19'h07FFF, 2'b10, 0, 1, 16'h0, 16'h0, 16'h1234);
    push_cyc(19'h00000, 2'b01, 0, 1, 16'h0, 16'h0, 16'hABCD);
    push_mem(1, 16'hCD12);
    run(20'h0FFFF, 16'h0, 0, 1, 0, 0, 0, 5);

    // wait states plus acks while stb is low
    push_cyc(19'h00100, 2'b10, 0, 0, 16'h0, 16'h0, 16'h7711);
    push_cyc(19'h00101, 2'b01, 0, 0, 16'h0, 16'h0, 16'h3355);
    push_mem(1, 16'h5577);
    run(20'h00201, 16'h0, 0, 0, 0, 3, 1, 11);
    push_cyc(19'h00200, 2'b11, 1, 0, 16'h1234, 16'hFFFF, 16'h0);
    push_mem(0, 16'h0);
    run(20'h00400, 16'h1234, 1, 0, 0, 2, 1, 5);

    // async reset in the middle of CYC2
    @(negedge clk);
    addr = 20'h00011; we = 1'b0; m_io = 1'b0; byteop = 1'b0; req = 1'b1;
    @(negedge clk);
    chk("r6_cyc1_idle", bus.wb_stb_o, 0);
    @(negedge clk);
    chk("r6_cyc1_stb", bus.wb_stb_o, 1);
    bus.wb_dat_i = 16'hEE00; bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("r6_gap", bus.wb_stb_o, 0);
    @(negedge clk);
    chk("r6_cyc2_stb", bus.wb_stb_o, 1);
    chk("r6_cyc2_adr", bus.wb_adr_o, 19'h00009);
    #1 rst_n = 1'b0;
    #1;
    chk("r6_rst_stb", bus.wb_stb_o, 0);
    chk("r6_rst_cyc", bus.wb_cyc_o, 0);
    chk("r6_rst_block", block, 0);
    chk("r6_rst_memout", memout, 0);
    req = 1'b0;
    model_mem = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;

    // req dropped while the first cycle is on the bus
    @(negedge clk);
    addr = 20'h00020; req = 1'b1;
    @(negedge clk);
    chk("rd_cyc1_idle", bus.wb_stb_o, 0);
    @(negedge clk);
    chk("rd_cyc1_stb", bus.wb_stb_o, 1);
    req = 1'b0;
    #1 chk("rd_block_drop", block, 0);
    @(negedge clk);
    chk("rd_stb_held", bus.wb_stb_o, 1);
    bus.wb_dat_i = 16'hDEAD; bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("rd_stb_end", bus.wb_stb_o, 0);
    chk("rd_memout", memout, model_mem);
    @(negedge clk);
    chk("rd_memout_hold", memout, model_mem);

    // normal access afterwards starts from IDLE
    push_cyc(19'h00001, 2'b11, 0, 0, 16'h0, 16'h0, 16'h0F0F);
    push_mem(1, 16'h0F0F);
    run(20'h00002, 16'h0, 0, 0, 0, 0, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
